times_table_loader: RTL
=======================

TIMES_TABLE_LOADER -- requirements
Module: times_table_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of table entry 0x0.
REQ-002 Parameter WSTRB_VAL, default 4'hF: byte strobe driven on every write beat.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  single-cycle load request, sampled only in IDLE.
REQ-006 Port busy  output  1  high from first cycle after accepted start until done pulse.
REQ-007 Port done  output  1  one-cycle pulse after the last write response.
REQ-008 Port error  output  1  sticky, set by any non-OKAY write response, cleared by next accepted start.
REQ-009 Port m_axi_awaddr  output  32  write address.
REQ-010 Port m_axi_awvalid / m_axi_awready  output / input  1 each  AW handshake.
REQ-011 Port m_axi_wdata  output  32  write data.
REQ-012 Port m_axi_wstrb  output  4  write strobe, equals WSTRB_VAL.
REQ-013 Port m_axi_wvalid / m_axi_wready  output / input  1 each  W handshake.
REQ-014 Port m_axi_bresp  input  2  write response code.
REQ-015 Port m_axi_bvalid / m_axi_bready  input / output  1 each  B handshake.

Function
REQ-016 The block SHALL initialise the 64-entry AXI4-Lite times-table memory that the multiplication stage later reads, one write per (a,b) pair, a,b in 0..7.
REQ-017 Entry index SHALL be a 6-bit counter {a[2:0],b[2:0]}, starting at 0, incrementing by 1 after each B handshake, b as the low bits.
REQ-018 m_axi_awaddr SHALL equal BASE_ADDR + {24'b0,a,b,2'b00} (32-bit add, wrap ignored).
REQ-019 m_axi_wdata SHALL equal {26'b0, a*b}, product computed as 6-bit unsigned (max 49).
REQ-020 FSM states: IDLE, WRITE, RESP, FINISH.
REQ-021 IDLE: start=1 -> WRITE, clear error, counter=0; start=0 -> stay.
REQ-022 WRITE: awvalid and wvalid SHALL both assert on entry; each SHALL drop the cycle after its own handshake (valid&ready) and not re-assert for that entry.
REQ-023 WRITE: awaddr/wdata/wstrb SHALL be stable while the respective valid is high; AW and W may complete in either order or the same cycle.
REQ-024 WRITE -> RESP once both AW and W handshakes have occurred (including same cycle).
REQ-025 RESP: bready SHALL be 1 (0 in all other states); on bvalid=1: bresp!=2'b00 sets error; counter!=63 -> counter+1, WRITE; counter==63 -> FINISH.
REQ-026 FINISH: done=1 for exactly one cycle, busy=0 in that cycle, next state IDLE.
REQ-027 A write error SHALL NOT abort the sequence; all 64 entries are always attempted.
REQ-028 start while busy or in FINISH SHALL be ignored with no side effect.
REQ-029 Minimum per-entry time SHALL be 2 cycles (WRITE, RESP) with ready/bvalid held high; full load 128 cycles from start to last B handshake, done on the following cycle.
REQ-030 No timeout: block SHALL wait indefinitely for any ready/bvalid.
REQ-031 Only one write SHALL be outstanding at any time.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, counter 0, busy 0, done 0, error 0, awvalid 0, wvalid 0, bready 0, awaddr BASE_ADDR, wdata 0.
REQ-033 Reset mid-transaction SHALL abandon the outstanding write with no completion attempt; next start restarts at entry 0.

Verification
REQ-034 Ideal slave (awready=wready=bvalid=1, bresp=0), start pulse -> 64 writes, entry (5,6) at addr 0x0000_00B8 data 30, done on cycle 129 after start, memory model equals a*b for all 64.
REQ-035 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awaddr stable 4 cycles, single B handshake, no duplicate write.
REQ-036 bresp=2'b10 on entry 17 only -> error=1 from that cycle, all 64 writes still issued, error held after done; new start clears error.
REQ-037 rst asserted while awvalid=1 on entry 20 -> all outputs zero same cycle; subsequent start first writes addr BASE_ADDR data 0.
REQ-038 start held high for 10 cycles and re-pulsed mid-load -> exactly 64 writes, one done pulse.
REQ-039 BASE_ADDR=32'h0000_1000 -> entry (7,7) at 0x0000_10FC data 49.

Source files
------------

// File: rtl/times_table_loader.sv
// -----------------------------------------------------------------------------
// times_table_loader
//
// Purpose:
//   Fills a 64-entry AXI4-Lite times-table memory with the products a*b for
//   a,b in 0..7. It issues exactly one write per entry and keeps only one
//   write outstanding at a time. A bad write response is remembered in a
//   sticky error flag, but it does not stop the sequence.
//
// Parameters:
//   BASE_ADDR  byte address of table entry 0
//   WSTRB_VAL  byte strobe driven on every write beat
//
// Ports:
//   clk            single clock; all logic runs on the rising edge
//   rst            asynchronous, active-high reset
//   start          single-cycle load request, sampled only while idle
//   busy           high while the load is in progress (WRITE/RESP)
//   done           one-cycle pulse after the last write response
//   error          sticky; set by any non-OKAY bresp, cleared by next start
//   m_axi_aw*      write address channel (awaddr, awvalid, awready)
//   m_axi_w*       write data channel (wdata, wstrb, wvalid, wready)
//   m_axi_b*       write response channel (bresp, bvalid, bready)
// -----------------------------------------------------------------------------
module times_table_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [3:0]  WSTRB_VAL = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_RESP   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'd63;

    // Product of the two 3-bit operands packed in the entry index
    // ({a,b}, with b in the low bits). The largest result is 7*7 = 49,
    // so 6 bits are enough.
    function automatic logic [5:0] f_entry_product(input logic [5:0] idx);
        logic [5:0] v_a;
        logic [5:0] v_b;
        v_a = {3'b000, idx[5:3]};
        v_b = {3'b000, idx[2:0]};
        return v_a * v_b;
    endfunction

    // Byte address of an entry: one 32-bit word per entry above BASE_ADDR.
    // The 32-bit sum is allowed to wrap.
    function automatic logic [31:0] f_entry_addr(input logic [5:0] idx);
        return BASE_ADDR + {24'b0, idx, 2'b00};
    endfunction

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_idx;
    logic [5:0] w_idx_next;
    logic       r_aw_done;
    logic       w_aw_done_next;
    logic       r_w_done;
    logic       w_w_done_next;
    logic       r_error;
    logic       w_error_next;

    logic       w_aw_hs;
    logic       w_w_hs;

    // Each valid stays up only until its own handshake completes. The
    // done flags keep it low for the rest of the entry, even if the other
    // channel is still waiting.
    assign m_axi_awvalid = (r_state == S_WRITE) && !r_aw_done;
    assign m_axi_wvalid  = (r_state == S_WRITE) && !r_w_done;
    assign m_axi_bready  = (r_state == S_RESP);

    // Address and data depend only on r_idx. r_idx changes only on a B
    // handshake, so both are stable while either valid is high.
    assign m_axi_awaddr  = f_entry_addr(r_idx);
    assign m_axi_wdata   = {26'b0, f_entry_product(r_idx)};
    assign m_axi_wstrb   = WSTRB_VAL;

    assign w_aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_w_hs  = m_axi_wvalid && m_axi_wready;

    assign busy  = (r_state == S_WRITE) || (r_state == S_RESP);
    assign done  = (r_state == S_FINISH);
    assign error = r_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 6'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_aw_done <= w_aw_done_next;
            r_w_done  <= w_w_done_next;
            r_error   <= w_error_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_aw_done_next = r_aw_done;
        w_w_done_next  = r_w_done;
        w_error_next   = r_error;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next   = S_WRITE;
                    w_idx_next     = 6'd0;
                    w_error_next   = 1'b0;
                    w_aw_done_next = 1'b0;
                    w_w_done_next  = 1'b0;
                end
            end

            S_WRITE: begin
                // AW and W may finish in either order or in the same
                // cycle. Move on once both have finished.
                w_aw_done_next = r_aw_done || w_aw_hs;
                w_w_done_next  = r_w_done || w_w_hs;
                if (w_aw_done_next && w_w_done_next) begin
                    w_state_next = S_RESP;
                end
            end

            S_RESP: begin
                // Clear the per-entry handshake flags here so the next
                // WRITE starts with both valids high.
                w_aw_done_next = 1'b0;
                w_w_done_next  = 1'b0;
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        w_error_next = 1'b1;
                    end
                    if (r_idx == LAST_IDX) begin
                        w_state_next = S_FINISH;
                    end else begin
                        w_idx_next   = r_idx + 6'd1;
                        w_state_next = S_WRITE;
                    end
                end
            end

            S_FINISH: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
